// File: rtl/isa_io_cycle_ctrl.sv
// ISA I/O cycle controller for the Sm2201 board: decodes the I/O window, drives the
// transceiver pair and IOCHRDY, and strobes CAMAC-side registers. Option: SM2201_BUSY_TIMEOUT_EN.
module isa_io_cycle_ctrl #(
    parameter logic [9:0] BASE_ADDR    = 10'h300,
    parameter logic [9:0] ADDR_MASK    = 10'h3FC,
    parameter int         WAIT_CYCLES  = 4,
    parameter int         BUSY_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] isa_addr,
    input  logic       isa_aen,
    input  logic       isa_ior_n,
    input  logic       isa_iow_n,
    input  logic       camac_busy,
    output logic       iochrdy_oe,
    output logic       xcvr_cs_n,
    output logic       xcvr_dce,
    output logic [1:0] reg_sel,
    output logic       rd_stb,
    output logic       wr_stb,
    output logic       cycle_err
);
    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || BUSY_TIMEOUT < 1 || BUSY_TIMEOUT > 255) begin : g_bad_param
            $error("isa_io_cycle_ctrl: parameter out of range");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_READ, S_WRITE, S_WAIT_BUSY, S_HOLD, S_RECOVER
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t     state_q, state_d;
    logic       ior_s1_q, ior_s2_q, ior_p_q;
    logic       iow_s1_q, iow_s2_q, iow_p_q;
    logic       is_wr_q, is_wr_d;
    logic [1:0] reg_sel_q, reg_sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ior_fall, iow_fall, hit, strb_hi, expired;

`ifdef SM2201_BUSY_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(BUSY_TIMEOUT - 1);
    logic [7:0] tmo_q, tmo_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`endif

    // Strobe sync flops reset high so reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {ior_s1_q, ior_s2_q, ior_p_q} <= 3'b111;
            {iow_s1_q, iow_s2_q, iow_p_q} <= 3'b111;
            state_q   <= S_IDLE;
            is_wr_q   <= 1'b0;
            reg_sel_q <= 2'b00;
            cnt_q     <= '0;
        end else begin
            {ior_s1_q, ior_s2_q, ior_p_q} <= {isa_ior_n, ior_s1_q, ior_s2_q};
            {iow_s1_q, iow_s2_q, iow_p_q} <= {isa_iow_n, iow_s1_q, iow_s2_q};
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            reg_sel_q <= reg_sel_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ior_fall = ior_p_q & ~ior_s2_q;
    assign iow_fall = iow_p_q & ~iow_s2_q;
    assign hit      = !isa_aen && ((isa_addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
    assign strb_hi  = is_wr_q ? iow_s2_q : ior_s2_q;
    assign expired  = (cnt_q >= CNT_LAST);
    assign reg_sel  = reg_sel_q;

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        reg_sel_d  = reg_sel_q;
        cnt_d      = cnt_q;
`ifdef SM2201_BUSY_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        xcvr_cs_n  = 1'b1;
        xcvr_dce   = 1'b0;
        iochrdy_oe = 1'b0;
        rd_stb     = 1'b0;
        wr_stb     = 1'b0;
        cycle_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((ior_fall || iow_fall) && hit) reg_sel_d = isa_addr[1:0];
                if (ior_fall && iow_fall) begin
                    cycle_err = 1'b1;
                end else if ((ior_fall || iow_fall) && hit) begin
                    state_d = S_SETUP;
                    is_wr_d = iow_fall;
                    cnt_d   = '0;
                end
            end
            // Direction is set here while the transceiver is still deselected.
            S_SETUP: begin
                xcvr_dce   = is_wr_q;
                iochrdy_oe = 1'b1;
                cnt_d      = cnt_q + 4'd1;
                if (strb_hi) begin
                    cycle_err = 1'b1;
                    state_d   = S_RECOVER;
                end else begin
                    state_d = is_wr_q ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                xcvr_cs_n  = 1'b0;
                iochrdy_oe = 1'b1;
                rd_stb     = (cnt_q == 4'd1);
                cnt_d      = cnt_q + 4'd1;
                if (strb_hi) begin
                    cycle_err = 1'b1;
                    state_d   = S_RECOVER;
                end else if (expired) begin
                    state_d = S_HOLD;
                end
            end
            S_WRITE: begin
                xcvr_cs_n  = 1'b0;
                xcvr_dce   = 1'b1;
                iochrdy_oe = 1'b1;
                cnt_d      = cnt_q + 4'd1;
                if (strb_hi) begin
                    cycle_err = 1'b1;
                    state_d   = S_RECOVER;
                end else if (expired) begin
                    if (!camac_busy) begin
                        wr_stb  = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_WAIT_BUSY;
`ifdef SM2201_BUSY_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
            end
            S_WAIT_BUSY: begin
                xcvr_cs_n  = 1'b0;
                xcvr_dce   = 1'b1;
                iochrdy_oe = 1'b1;
                if (strb_hi) begin
                    cycle_err = 1'b1;
                    state_d   = S_RECOVER;
                end else if (!camac_busy) begin
                    wr_stb  = 1'b1;
                    state_d = S_HOLD;
                end
`ifdef SM2201_BUSY_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    cycle_err = 1'b1;
                    state_d   = S_HOLD;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            S_HOLD: begin
                xcvr_cs_n = 1'b0;
                xcvr_dce  = is_wr_q;
                if (strb_hi) state_d = S_RECOVER;
            end
            // Direction drops back to read only once back in IDLE.
            S_RECOVER: begin
                xcvr_dce = is_wr_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_isa_io_cycle_ctrl.sv
// Directed bench for isa_io_cycle_ctrl: per-transaction pulse counts and latencies
// are gathered by a negedge monitor and compared with hand-derived values.
module tb_isa_io_cycle_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] isa_addr = 10'h000;
    logic       isa_aen = 1'b0;
    logic       isa_ior_n = 1'b1;
    logic       isa_iow_n = 1'b1;
    logic       camac_busy = 1'b0;
    logic       iochrdy_oe, xcvr_cs_n, xcvr_dce, rd_stb, wr_stb, cycle_err;
    logic [1:0] reg_sel;

    isa_io_cycle_ctrl #(
        .BASE_ADDR(10'h300), .ADDR_MASK(10'h3FC), .WAIT_CYCLES(4), .BUSY_TIMEOUT(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .isa_addr(isa_addr), .isa_aen(isa_aen),
        .isa_ior_n(isa_ior_n), .isa_iow_n(isa_iow_n), .camac_busy(camac_busy),
        .iochrdy_oe(iochrdy_oe), .xcvr_cs_n(xcvr_cs_n), .xcvr_dce(xcvr_dce),
        .reg_sel(reg_sel), .rd_stb(rd_stb), .wr_stb(wr_stb), .cycle_err(cycle_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    int   n_rd, n_wr, n_err, n_oe, n_cs, n_dpre, viol = 0;
    int   t_cs_fall, t_cs_rise, t_rd, t_wr, t_err;
    logic prev_cs = 1'b1, prev_dce = 1'b0;

    task automatic clr();
        n_rd = 0; n_wr = 0; n_err = 0; n_oe = 0; n_cs = 0; n_dpre = 0;
        t_cs_fall = -1; t_cs_rise = -1; t_rd = -1; t_wr = -1; t_err = -1;
    endtask

    always @(negedge clk) begin
        if (rd_stb) begin n_rd++; if (t_rd < 0) t_rd = cyc; end
        if (wr_stb) begin n_wr++; if (t_wr < 0) t_wr = cyc; end
        if (cycle_err) begin n_err++; if (t_err < 0) t_err = cyc; end
        if (iochrdy_oe) n_oe++;
        if (!xcvr_cs_n) begin n_cs++; if (t_cs_fall < 0) t_cs_fall = cyc; end
        if (xcvr_cs_n && !prev_cs && t_cs_rise < 0) t_cs_rise = cyc;
        if (xcvr_cs_n && xcvr_dce) n_dpre++;
        if (rd_stb && wr_stb) viol++;
        if (!xcvr_cs_n && !prev_cs && xcvr_dce !== prev_dce) viol++;
        prev_cs  = xcvr_cs_n;
        prev_dce = xcvr_dce;
    end

    task automatic ticks(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int c0;
    initial begin
        clr();
        #1;
        chk("rst_cs_n", xcvr_cs_n, 1);
        chk("rst_dce", xcvr_dce, 0);
        chk("rst_oe", iochrdy_oe, 0);
        chk("rst_strobes", {rd_stb, wr_stb, cycle_err}, 0);
        chk("rst_reg_sel", reg_sel, 0);
        ticks(3); rst_n = 1'b1; ticks(4);

        // read at 0x301, IOR# low 20 clocks
        clr(); isa_addr = 10'h301; isa_ior_n = 1'b0; c0 = cyc;
        ticks(20); isa_ior_n = 1'b1; ticks(6);
        chk("rd_cs_lat", t_cs_fall - c0, 4);
        chk("rd_stb_lat", t_rd - c0, 4);
        chk("rd_stb_cnt", n_rd, 1);
        chk("rd_no_wr", n_wr + n_err, 0);
        chk("rd_oe_cnt", n_oe, 4);
        chk("rd_cs_low", n_cs, 19);
        chk("rd_cs_rise", t_cs_rise - c0, 23);
        chk("rd_dce", n_dpre, 0);
        chk("rd_reg_sel", reg_sel, 1);

        // write at 0x302, not busy
        clr(); isa_addr = 10'h302; isa_iow_n = 1'b0; c0 = cyc;
        ticks(12); isa_iow_n = 1'b1; ticks(6);
        chk("wr_stb_lat", t_wr - c0, 6);
        chk("wr_stb_cnt", n_wr, 1);
        chk("wr_no_rd", n_rd + n_err, 0);
        chk("wr_oe_cnt", n_oe, 4);
        chk("wr_dce_desel", n_dpre, 2);
        chk("wr_reg_sel", reg_sel, 2);

        // write at 0x300, busy for 10 clocks
        clr(); isa_addr = 10'h300; camac_busy = 1'b1; isa_iow_n = 1'b0; c0 = cyc;
        ticks(10); camac_busy = 1'b0; ticks(4); isa_iow_n = 1'b1; ticks(6);
        chk("busy_wr_lat", t_wr - c0, 10);
        chk("busy_wr_cnt", n_wr, 1);
        chk("busy_oe_cnt", n_oe, 8);
        chk("busy_err", n_err, 0);
        chk("busy_reg_sel", reg_sel, 0);

`ifdef SM2201_BUSY_TIMEOUT_EN
        clr(); camac_busy = 1'b1; isa_iow_n = 1'b0; c0 = cyc;
        ticks(16); isa_iow_n = 1'b1; ticks(3); camac_busy = 1'b0; ticks(4);
        chk("tmo_err_cnt", n_err, 1);
        chk("tmo_err_lat", t_err - c0, 11);
        chk("tmo_no_wr", n_wr, 0);
        chk("tmo_oe_cnt", n_oe, 9);
`endif

        // misses: outside window, then DMA cycle inside window
        clr(); isa_addr = 10'h313; isa_ior_n = 1'b0;
        ticks(8); isa_ior_n = 1'b1; ticks(4);
        isa_addr = 10'h303; isa_aen = 1'b1; isa_iow_n = 1'b0;
        ticks(8); isa_iow_n = 1'b1; isa_aen = 1'b0; ticks(4);
        chk("miss_cs", n_cs, 0);
        chk("miss_oe", n_oe, 0);
        chk("miss_strobes", n_rd + n_wr + n_err, 0);
        chk("miss_reg_sel", reg_sel, 0);

        // early IOW# release
        clr(); isa_addr = 10'h301; isa_iow_n = 1'b0; c0 = cyc;
        ticks(3); isa_iow_n = 1'b1; ticks(6);
        chk("early_err_cnt", n_err, 1);
        chk("early_err_lat", t_err - c0, 5);
        chk("early_no_wr", n_wr, 0);
        chk("early_cs_low", n_cs, 2);
        chk("early_cs_rise", t_cs_rise - c0, 6);

        // both strobes fall together
        clr(); isa_addr = 10'h300; isa_ior_n = 1'b0; isa_iow_n = 1'b0; c0 = cyc;
        ticks(6); isa_ior_n = 1'b1; isa_iow_n = 1'b1; ticks(4);
        chk("both_err_cnt", n_err, 1);
        chk("both_err_lat", t_err - c0, 2);
        chk("both_idle", n_cs + n_oe + n_rd + n_wr, 0);

        // reset during WAIT_BUSY
        clr(); isa_addr = 10'h302; camac_busy = 1'b1; isa_iow_n = 1'b0; c0 = cyc;
        ticks(8);
        chk("pre_rst_oe", iochrdy_oe, 1);
        rst_n = 1'b0; #1;
        chk("mid_rst_cs_n", xcvr_cs_n, 1);
        chk("mid_rst_dce", xcvr_dce, 0);
        chk("mid_rst_oe", iochrdy_oe, 0);
        chk("mid_rst_reg_sel", reg_sel, 0);
        isa_iow_n = 1'b1; ticks(2); rst_n = 1'b1; ticks(2); camac_busy = 1'b0; ticks(6);
        chk("mid_rst_no_wr", n_wr, 0);

        chk("invariants", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/isa_io_cycle_ctrl.md
Name: isa_io_cycle_ctrl

Overview:
- ISA-side I/O cycle controller for the Sm2201 interface board.
- Decodes ISA I/O reads and writes aimed at the board's address window.
- Drives the 8216-style transceiver control pair (xcvr_cs_n, xcvr_dce) and holds IOCHRDY low to insert wait states.
- Issues one-cycle register strobes to the CAMAC-side logic and waits on its busy flag before completing writes.

Parameters:
- BASE_ADDR, 10'h300: board I/O base address.
- ADDR_MASK, 10'h3FC: address bits compared on decode.
- WAIT_CYCLES, 4: minimum clocks IOCHRDY is held low per cycle (1..15).
- BUSY_TIMEOUT, 255: maximum clocks spent waiting on camac_busy (1..255; used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- isa_addr  in  10  ISA SA[9:0].
- isa_aen  in  1  ISA AEN; 1 = DMA cycle, never decode.
- isa_ior_n  in  1  ISA IOR#, asynchronous.
- isa_iow_n  in  1  ISA IOW#, asynchronous.
- camac_busy  in  1  CAMAC side is not ready to accept a write.
- iochrdy_oe  out  1  1 = pull IOCHRDY low (open-drain enable).
- xcvr_cs_n  out  1  transceiver chip select, active-low.
- xcvr_dce  out  1  transceiver direction; 0 = d_in->d_bus (ISA read), 1 = d_bus->d_out (ISA write).
- reg_sel  out  2  latched isa_addr[1:0] for the current cycle.
- rd_stb  out  1  one-clock read strobe.
- wr_stb  out  1  one-clock write strobe.
- cycle_err  out  1  one-clock error pulse.

Behaviour:
- Decided: single clock clk; rst_n asynchronous, active-low. While rst_n=0, all outputs are 0 except xcvr_cs_n=1. This applies mid-cycle too: a cycle cut by reset is dropped with no strobe.
- Sync: isa_ior_n and isa_iow_n each pass through 2 flops. A falling edge is detected on synced bits. isa_addr and isa_aen are sampled in the detect cycle.
- hit = (isa_aen==0) && ((isa_addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)). reg_sel is loaded on hit and held until the next hit.
- States: IDLE, SETUP, READ, WRITE, WAIT_BUSY, HOLD, RECOVER.
- IDLE: xcvr_cs_n=1, xcvr_dce=0, iochrdy_oe=0.
  - Edge on a single strobe with hit -> SETUP.
  - Edge with no hit -> stay in IDLE, outputs unchanged.
  - Both strobes fall in the same clock -> cycle_err pulse, stay in IDLE.
- SETUP (1 clock):
  - xcvr_dce = 1 for a write, 0 for a read. xcvr_cs_n stays 1, so direction changes only while deselected.
  - iochrdy_oe = 1 from this state onward.
  - Next state: READ or WRITE.
- READ:
  - xcvr_cs_n=0; rd_stb pulses on the first clock.
  - Wait counter runs WAIT_CYCLES clocks, counted from SETUP entry. Then iochrdy_oe=0 -> HOLD.
- WRITE:
  - xcvr_cs_n=0, xcvr_dce=1; counter as in READ.
  - At expiry with camac_busy=0: wr_stb pulses, iochrdy_oe=0 -> HOLD.
  - At expiry with camac_busy=1: -> WAIT_BUSY.
- WAIT_BUSY: iochrdy_oe stays 1. The first clock with camac_busy=0 gives wr_stb pulse, iochrdy_oe=0 -> HOLD.
- HOLD: xcvr_cs_n=0. Stay until the synced active strobe is high -> RECOVER.
- Early release: the strobe rises in SETUP, READ, WRITE or WAIT_BUSY.
  - Goes straight to RECOVER with a cycle_err pulse.
  - A write aborted this way produces no wr_stb.
  - A read's rd_stb is not retracted.
- RECOVER (1 clock): xcvr_cs_n=1, iochrdy_oe=0; xcvr_dce returns to 0 on the following clock in IDLE. New edges seen here are ignored; the next edge must occur in IDLE.
- Latency: xcvr_cs_n falls 2 clocks after the detect clock, and rd_stb fires in the same clock. The detect clock is 2 clocks after the pin edge.
- Invariants: xcvr_dce never changes while xcvr_cs_n=0; rd_stb and wr_stb are never both 1.

Optional Feature:
- Macro: SM2201_BUSY_TIMEOUT_EN.
- Defined: an 8-bit counter runs in WAIT_BUSY. After BUSY_TIMEOUT clocks with camac_busy still 1:
  - cycle_err pulses;
  - iochrdy_oe=0;
  - no wr_stb is issued;
  - the FSM goes to HOLD.
- Not defined: WAIT_BUSY waits indefinitely, and the BUSY_TIMEOUT parameter is unused.

Test Plan:
- Read at 0x301, aen=0, IOR# low 20 clocks -> xcvr_dce=0; xcvr_cs_n falls 2 clocks after detect; rd_stb once; reg_sel=2'b01; iochrdy_oe high 4 clocks; cs_n=1 one clock after IOR# synced high.
- Write at 0x302, camac_busy=0 -> SETUP shows dce=1 with cs_n=1; wr_stb once after 4 clocks; reg_sel=2'b10; no rd_stb.
- Write at 0x300 with camac_busy=1 for 10 clocks -> iochrdy_oe held until busy drops; wr_stb on the first not-busy clock. With SM2201_BUSY_TIMEOUT_EN and BUSY_TIMEOUT=5, busy stuck at 1 -> cycle_err after 5 clocks, no wr_stb.
- Address 0x310, or 0x300 with aen=1 -> no change on cs_n, iochrdy_oe or any strobe.
- IOW# released 2 clocks after detect -> cycle_err pulse, no wr_stb, cs_n=1 in RECOVER. IOR# and IOW# falling together -> cycle_err, FSM stays in IDLE.
- rst_n pulsed low during WAIT_BUSY -> immediate cs_n=1, dce=0, iochrdy_oe=0; no wr_stb after release.
